// File: rtl/asg_pkg.sv
// asg_pkg: shared widths, sample types and saturation limits for the asg DSP stages
package asg_pkg;
    localparam int ASG_DWI = 14;
    localparam int ASG_DWO = 14;
    localparam int ASG_DWM = 16;
    localparam int ASG_DWS = 14;
    localparam int ASG_CWS = 32;
    typedef logic signed [ASG_DWI-1:0] asg_smp_i_t;
    typedef logic signed [ASG_DWO-1:0] asg_smp_o_t;
    typedef logic signed [ASG_DWS-1:0] asg_sum_t;
    typedef logic signed [ASG_DWM-1:0] asg_mul_t;
    localparam int ASG_GAIN_ONE = 2 ** (ASG_DWM - 2);
    localparam int ASG_SAT_MAX = 2 ** (ASG_DWO - 1) - 1;
    localparam int ASG_SAT_MIN = -(2 ** (ASG_DWO - 1));
endpackage

// File: rtl/asg_lin_sat.sv
// asg_lin_sat: combinational signed saturation from WI bits down to WO bits
module asg_lin_sat #(
    parameter int WI = 17,
    parameter int WO = 14
) (
    input  logic signed [WI-1:0] dat_i,
    output logic signed [WO-1:0] dat_o,
    output logic                 sat_o
);
    logic [WI-WO:0] hi;
    // in range only when every bit from the output sign upward matches
    assign hi    = dat_i[WI-1:WO-1];
    assign sat_o = ~(&hi | ~|hi);
    assign dat_o = sat_o ? {dat_i[WI-1], {(WO-1){~dat_i[WI-1]}}} : dat_i[WO-1:0];
endmodule

// File: rtl/asg_lin.sv
// asg_lin: 2-stage AXI4-stream gain/offset/saturation stage with saturation status
module asg_lin import asg_pkg::*; #(
    parameter int DWI = ASG_DWI,
    parameter int DWO = ASG_DWO,
    parameter int DWM = ASG_DWM,
    parameter int DWS = ASG_DWS,
    parameter int CWS = ASG_CWS
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  ctl_rst,
    input  logic                  ctl_clr,
    input  logic signed [DWM-1:0] cfg_mul,
    input  logic signed [DWS-1:0] cfg_sum,
    input  logic signed [DWI-1:0] sti_tdata,
    input  logic                  sti_tkeep,
    input  logic                  sti_tlast,
    input  logic                  sti_tvalid,
    output logic                  sti_tready,
    output logic signed [DWO-1:0] sto_tdata,
    output logic                  sto_tkeep,
    output logic                  sto_tlast,
    output logic                  sto_tvalid,
    input  logic                  sto_tready,
    output logic                  sts_sat,
    output logic [CWS-1:0]        sts_cnt
);
    localparam int PW = DWI + DWM;
    logic                  v1_q, k1_q, l1_q, v2_q, k2_q, l2_q, sat_q, sat_d;
    logic signed [PW-1:0]  p1_q;
    logic signed [DWO-1:0] d2_q, y;
    logic signed [DWI+2:0] s;
    logic [CWS-1:0]        cnt_q, cnt_d;
    logic                  adv1, adv2, sat, sat_ev, unused_lsb;
    assign adv2       = ~v2_q | sto_tready;
    assign adv1       = ~v1_q | adv2;
    assign sti_tready = adv1 | ctl_rst;
    // slicing p1 above the fraction bits is the floor shift
    assign s = {p1_q[PW-1], p1_q[PW-1:DWM-2]} + {{(DWI+3-DWS){cfg_sum[DWS-1]}}, cfg_sum};
    assign unused_lsb = ^p1_q[DWM-3:0];
    asg_lin_sat #(.WI(DWI + 3), .WO(DWO)) u_sat (.dat_i(s), .dat_o(y), .sat_o(sat));
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v1_q <= 1'b0;
            k1_q <= 1'b0;
            l1_q <= 1'b0;
            p1_q <= '0;
            v2_q <= 1'b0;
            k2_q <= 1'b0;
            l2_q <= 1'b0;
            d2_q <= '0;
        end else begin
            v1_q <= ctl_rst ? 1'b0 : adv1 ? sti_tvalid : v1_q;
            v2_q <= ctl_rst ? 1'b0 : adv2 ? v1_q : v2_q;
            if (adv1 && sti_tvalid) begin
                p1_q <= $signed(PW'(sti_tdata)) * $signed(PW'(cfg_mul));
                k1_q <= sti_tkeep;
                l1_q <= sti_tlast;
            end
            if (adv2 && v1_q) begin
                d2_q <= y;
                k2_q <= k1_q;
                l2_q <= l1_q;
            end
        end
    end
    // a clear in the same cycle as an event restarts the count at that event
    assign sat_ev = adv2 & v1_q & ~ctl_rst & sat;
    always_comb begin
        sat_d = sat_ev | (sat_q & ~ctl_clr);
        cnt_d = ctl_clr ? CWS'(sat_ev) : (sat_ev & ~&cnt_q) ? cnt_q + CWS'(1) : cnt_q;
    end
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sat_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            sat_q <= sat_d;
            cnt_q <= cnt_d;
        end
    end
    assign sto_tdata  = d2_q;
    assign sto_tkeep  = k2_q;
    assign sto_tlast  = l2_q;
    assign sto_tvalid = v2_q;
    assign sts_sat    = sat_q;
    assign sts_cnt    = cnt_q;
endmodule

// File: tb/tb_asg_lin.sv
// tb_asg_lin: directed and randomized checks of asg_lin against an arithmetic reference model
module tb_asg_lin;
    logic               clk = 1'b0;
    logic               rstn, ctl_rst, ctl_clr;
    logic signed [15:0] cfg_mul;
    logic signed [13:0] cfg_sum;
    logic signed [13:0] sti_tdata;
    logic               sti_tkeep, sti_tlast, sti_tvalid, sti_tready;
    logic signed [13:0] sto_tdata;
    logic               sto_tkeep, sto_tlast, sto_tvalid, sto_tready;
    logic               sts_sat;
    logic [31:0]        sts_cnt;
    int tests = 0, fails = 0;
    bit o_ir, o_v, o_k, o_l;
    int o_d;
    typedef struct {int d; bit k; bit l;} exp_t;
    exp_t q[$];

    always #5 clk = ~clk;

    asg_lin dut (
        .clk(clk), .rstn(rstn), .ctl_rst(ctl_rst), .ctl_clr(ctl_clr),
        .cfg_mul(cfg_mul), .cfg_sum(cfg_sum),
        .sti_tdata(sti_tdata), .sti_tkeep(sti_tkeep), .sti_tlast(sti_tlast),
        .sti_tvalid(sti_tvalid), .sti_tready(sti_tready),
        .sto_tdata(sto_tdata), .sto_tkeep(sto_tkeep), .sto_tlast(sto_tlast),
        .sto_tvalid(sto_tvalid), .sto_tready(sto_tready),
        .sts_sat(sts_sat), .sts_cnt(sts_cnt)
    );

    // y = clamp(floor(x*m / 2^14) + s) to the signed 14-bit range
    function automatic int model(input int x, input int m, input int s, output bit sat);
        longint p = longint'(x) * longint'(m);
        longint r = p / 16384;
        if (p < 0 && p % 16384 != 0) r = r - 1;
        r = r + s;
        sat = (r > 8191) || (r < -8192);
        if (r > 8191) r = 8191;
        if (r < -8192) r = -8192;
        return int'(r);
    endfunction

    // drive one cycle at the falling edge, then capture what the DUT shows before the next rising edge
    task automatic step(input bit v, input int d, input bit k, input bit l, input bit r, input bit clr, input bit frst);
        @(negedge clk);
        sti_tvalid = v;
        sti_tdata  = 14'(d);
        sti_tkeep  = k;
        sti_tlast  = l;
        sto_tready = r;
        ctl_clr    = clr;
        ctl_rst    = frst;
        #1;
        o_ir = sti_tready;
        o_v  = sto_tvalid;
        o_d  = sto_tdata;
        o_k  = sto_tkeep;
        o_l  = sto_tlast;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        #1;
        tests++; if (sti_tready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b expected 1", sti_tready); end
        tests++; if (sto_tvalid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", sto_tvalid); end
        tests++; if (sto_tdata !== 14'sd0 || sto_tkeep !== 1'b0 || sto_tlast !== 1'b0) begin fails++; $display("FAIL reset_data: got %0d/%b/%b expected 0/0/0", sto_tdata, sto_tkeep, sto_tlast); end
        tests++; if (sts_sat !== 1'b0 || sts_cnt !== 32'd0) begin fails++; $display("FAIL reset_status: got %b/%0d expected 0/0", sts_sat, sts_cnt); end
        rstn = 1'b1;
    endtask

    task automatic test_unity;
        int acc = -1, first = -1, lastc = -1, n = 0;
        cfg_mul = 16'sd16384;
        cfg_sum = 14'sd0;
        for (int c = 0; c < 30; c++) begin
            step(c < 16, c, 1'b1, c == 15, 1'b1, 1'b0, 1'b0);
            if (c < 16 && o_ir && acc < 0) acc = c;
            if (o_v) begin
                if (first < 0) first = c;
                lastc = c;
                tests++; if (o_d !== n || o_l !== (n == 15) || o_k !== 1'b1) begin fails++; $display("FAIL unity_data: got %0d last %b expected %0d last %b", o_d, o_l, n, n == 15); end
                n++;
            end
        end
        tests++; if (n !== 16) begin fails++; $display("FAIL unity_count: got %0d expected 16", n); end
        tests++; if (first - acc !== 2) begin fails++; $display("FAIL unity_latency: got %0d expected 2", first - acc); end
        tests++; if (lastc - first !== 15) begin fails++; $display("FAIL unity_gaps: got span %0d expected 15", lastc - first); end
    endtask

    task automatic test_gain_offset;
        int got[$];
        int g0, g1;
        cfg_mul = 16'sd8192;
        cfg_sum = 14'sd100;
        for (int c = 0; c < 8; c++) begin
            step(c < 2, (c == 0) ? 200 : -201, 1'b1, c == 1, 1'b1, 1'b0, 1'b0);
            if (o_v) got.push_back(o_d);
        end
        g0 = (got.size() > 0) ? got[0] : 99999;
        g1 = (got.size() > 1) ? got[1] : 99999;
        tests++; if (got.size() !== 2) begin fails++; $display("FAIL gain_count: got %0d expected 2", got.size()); end
        tests++; if (g0 !== 200) begin fails++; $display("FAIL gain_pos: got %0d expected 200", g0); end
        tests++; if (g1 !== -1) begin fails++; $display("FAIL gain_neg_floor: got %0d expected -1", g1); end
    endtask

    task automatic test_saturation;
        int xs[3] = '{8191, -8192, 100};
        int got[$];
        int e, g, exp_cnt = 0;
        bit s;
        cfg_mul = 16'sd32767;
        cfg_sum = 14'sd0;
        step(1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int c = 0; c < 10; c++) begin
            step(c < 3, (c < 3) ? xs[c] : 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
            if (o_v) got.push_back(o_d);
        end
        for (int i = 0; i < 3; i++) begin
            e = model(xs[i], 32767, 0, s);
            exp_cnt += int'(s);
            g = (got.size() > i) ? got[i] : 99999;
            tests++; if (g !== e) begin fails++; $display("FAIL sat_data[%0d]: got %0d expected %0d", i, g, e); end
        end
        tests++; if (sts_sat !== (exp_cnt > 0) || sts_cnt !== 32'(exp_cnt)) begin fails++; $display("FAIL sat_status: got %b/%0d expected %b/%0d", sts_sat, sts_cnt, exp_cnt > 0, exp_cnt); end
        step(1'b1, 8191, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tests++; if (sts_sat !== 1'b1 || sts_cnt !== 32'd1) begin fails++; $display("FAIL sat_clr_with_event: got %b/%0d expected 1/1", sts_sat, sts_cnt); end
        step(1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tests++; if (sts_sat !== 1'b0 || sts_cnt !== 32'd0) begin fails++; $display("FAIL sat_clear: got %b/%0d expected 0/0", sts_sat, sts_cnt); end
    endtask

    task automatic test_backpressure;
        int sent = 0, rcvd = 0, cyc = 0, pd = 0, x, m, sm;
        bit pv = 0, pr = 1, pk = 0, pl = 0, v, r, k, l, s, exp_ir;
        exp_t e;
        cfg_mul = 16'($urandom_range(0, 65535));
        cfg_sum = 14'($urandom_range(0, 16383));
        m = cfg_mul;
        sm = cfg_sum;
        q.delete();
        while ((sent < 1000 || q.size() > 0) && cyc < 8000) begin
            v = (sent < 1000) && ($urandom % 10 < 7);
            r = ($urandom % 2) == 1;
            k = ($urandom % 2) == 1;
            l = (sent % 100) == 99;
            x = sent - 500;
            step(v, x, k, l, r, 1'b0, 1'b0);
            exp_ir = !(q.size() == 2 && !r);
            tests++; if (o_ir !== exp_ir) begin fails++; $display("FAIL bp_ready: cycle %0d got %b expected %b", cyc, o_ir, exp_ir); end
            if (pv && !pr) begin
                tests++; if (o_v !== 1'b1 || o_d !== pd || o_k !== pk || o_l !== pl) begin fails++; $display("FAIL bp_stable: cycle %0d got %b/%0d/%b/%b expected 1/%0d/%b/%b", cyc, o_v, o_d, o_k, o_l, pd, pk, pl); end
            end
            if (o_v && r) begin
                tests++;
                if (q.size() == 0) begin fails++; $display("FAIL bp_extra: cycle %0d got %0d expected nothing", cyc, o_d); end
                else begin
                    e = q.pop_front();
                    if (o_d !== e.d || o_k !== e.k || o_l !== e.l) begin fails++; $display("FAIL bp_data: sample %0d got %0d/%b/%b expected %0d/%b/%b", rcvd, o_d, o_k, o_l, e.d, e.k, e.l); end
                end
                rcvd++;
            end
            if (v && o_ir) begin
                e.d = model(x, m, sm, s);
                e.k = k;
                e.l = l;
                q.push_back(e);
                sent++;
            end
            pv = o_v; pr = r; pd = o_d; pk = o_k; pl = o_l;
            cyc++;
        end
        tests++; if (sent !== 1000 || rcvd !== 1000) begin fails++; $display("FAIL bp_complete: got sent %0d received %0d expected 1000/1000", sent, rcvd); end
    endtask

    task automatic test_flush;
        int got[$], gc[$];
        int g0, c0;
        cfg_mul = 16'sd16384;
        cfg_sum = 14'sd0;
        step(1'b1, 11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 22, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 33, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        tests++; if (o_ir !== 1'b1 || o_v !== 1'b1) begin fails++; $display("FAIL flush_ready: got ready %b valid %b expected 1/1", o_ir, o_v); end
        step(1'b1, 44, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        tests++; if (o_v !== 1'b0) begin fails++; $display("FAIL flush_valid: got %b expected 0", o_v); end
        for (int c = 1; c < 7; c++) begin
            step(1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            if (o_v) begin got.push_back(o_d); gc.push_back(c); end
        end
        g0 = (got.size() > 0) ? got[0] : 99999;
        c0 = (gc.size() > 0) ? gc[0] : -1;
        tests++; if (got.size() !== 1) begin fails++; $display("FAIL flush_count: got %0d expected 1", got.size()); end
        tests++; if (g0 !== 44 || c0 !== 2) begin fails++; $display("FAIL flush_next: got %0d at %0d expected 44 at 2", g0, c0); end
    endtask

    task automatic test_async_reset;
        cfg_mul = 16'sd32767;
        cfg_sum = 14'sd0;
        step(1'b1, 8191, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8191, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tests++; if (o_v !== 1'b1 || sts_sat !== 1'b1) begin fails++; $display("FAIL arst_pre: got valid %b sat %b expected 1/1", o_v, sts_sat); end
        #2;
        rstn = 1'b0;
        #1;
        tests++; if (sto_tvalid !== 1'b0 || sto_tdata !== 14'sd0 || sto_tkeep !== 1'b0 || sto_tlast !== 1'b0) begin fails++; $display("FAIL arst_out: got %b/%0d/%b/%b expected 0/0/0/0", sto_tvalid, sto_tdata, sto_tkeep, sto_tlast); end
        tests++; if (sts_sat !== 1'b0 || sts_cnt !== 32'd0) begin fails++; $display("FAIL arst_status: got %b/%0d expected 0/0", sts_sat, sts_cnt); end
        tests++; if (sti_tready !== 1'b1) begin fails++; $display("FAIL arst_ready: got %b expected 1", sti_tready); end
        @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        rstn = 1'b0; ctl_rst = 1'b0; ctl_clr = 1'b0;
        cfg_mul = '0; cfg_sum = '0;
        sti_tvalid = 1'b0; sti_tdata = '0; sti_tkeep = 1'b0; sti_tlast = 1'b0; sto_tready = 1'b0;
        test_reset;
        test_unity;
        test_gain_offset;
        test_saturation;
        test_backpressure;
        test_flush;
        test_async_reset;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
